// File: rtl/step_sequencer.sv
// step_sequencer: multi-cycle CPU step sequencer with fetch/IR capture, memory handshake + timeout, halt/resume, retire counter
// Ports: iClk/iRst clock and async reset; iEn freezes all state when low;
//   iMemNeed/iMemAck/iMemData memory handshake and read data; iLast/iHalt end-of-instruction and HLT marks; iResume leaves HALT;
//   oMemReq request level; oStep/oStepIdx current step (one-hot/binary); oAdvance step moves at next edge;
//   oIR/oIRValid instruction register; oHalted/oFault state flags; oInstrCount retired instructions.
module step_sequencer #(
  parameter int N_STEPS = 5,
  parameter int IR_W    = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16,
  localparam int SW     = $clog2(N_STEPS),
  localparam int TW     = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iMemNeed,
  input  logic              iMemAck,
  input  logic [IR_W-1:0]   iMemData,
  input  logic              iLast,
  input  logic              iHalt,
  input  logic              iResume,
  output logic              oMemReq,
  output logic [N_STEPS-1:0] oStep,
  output logic [SW-1:0]     oStepIdx,
  output logic              oAdvance,
  output logic [IR_W-1:0]   oIR,
  output logic              oIRValid,
  output logic              oHalted,
  output logic              oFault,
  output logic [CNT_W-1:0]  oInstrCount
);
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             mem_step, last, timeout_hit;
  logic [N_STEPS-1:0] one;
  always_comb begin
    one         = '0;
    one[0]      = 1'b1;
    mem_step    = (step_q == '0) | iMemNeed;
    // reset gates the combinational handshake so the request drops immediately
    oMemReq     = ~iRst & (state_q == RUN) & iEn & mem_step;
    oAdvance    = ~iRst & (state_q == RUN) & iEn & (~mem_step | iMemAck);
    last        = iLast | (step_q == SW'(N_STEPS - 1));
    // fault on the unacked edge that would bring the wait count up to TIMEOUT
    timeout_hit = (TIMEOUT != 0) & oMemReq & ~iMemAck & (wait_q == TW'(TIMEOUT - 1));
    state_d     = state_q;
    step_d      = step_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    if (oAdvance) begin
      wait_d = '0;
      if (step_q == '0) begin
        ir_d       = iMemData;
        ir_valid_d = 1'b1;
      end
      if (last) begin
        step_d  = '0;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = iHalt ? HALT : RUN;
      end else begin
        step_d = step_q + SW'(1);
      end
    end else if (oMemReq) begin
      wait_d  = wait_q + TW'(1);
      state_d = timeout_hit ? FAULT : state_q;
    end
    if (state_q == HALT && iEn && iResume) state_d = RUN;
  end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= RUN;
      step_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
    end
  end
  assign oStep       = one << step_q;
  assign oStepIdx    = step_q;
  assign oIR         = ir_q;
  assign oIRValid    = ir_valid_q;
  assign oHalted     = state_q == HALT;
  assign oFault      = state_q == FAULT;
  assign oInstrCount = cnt_q;
endmodule
